// File: rtl/ahblite_uart.sv
// AHB-Lite slave for the UART register window.
// Offsets: 0x0 RXDATA (read pops RX FIFO), 0x4 STATE, 0x8 TXDATA, 0xC reserved.
// Received bytes go into a small circular FIFO. Transmit bytes are handed to
// the TX core with a one-cycle strobe, and the bus is stalled while the core
// is busy.
module ahblite_uart #(
  parameter int RX_DEPTH = 4
) (
  input  logic        HCLK,
  input  logic        HRESETn,
  input  logic        HSEL,
  input  logic [31:0] HADDR,
  input  logic [1:0]  HTRANS,
  input  logic [2:0]  HSIZE,
  input  logic [3:0]  HPROT,
  input  logic        HWRITE,
  input  logic [31:0] HWDATA,
  input  logic        HREADY,
  output logic        HREADYOUT,
  output logic [31:0] HRDATA,
  output logic        HRESP,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        tx_busy,
  output logic [7:0]  tx_data,
  output logic        tx_en,
  output logic        uart_irq
);

  localparam int          PW       = $clog2(RX_DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(RX_DEPTH);

  localparam logic [1:0] A_RXDATA = 2'd0;
  localparam logic [1:0] A_STATE  = 2'd1;
  localparam logic [1:0] A_TXDATA = 2'd2;

  // Registered data-phase context
  logic          rd_act_q, rd_act_d;
  logic          wr_act_q, wr_act_d;
  logic [1:0]    addr_q, addr_d;

  // TX handshake
  logic [7:0]    tx_data_q, tx_data_d;
  logic          tx_en_q, tx_en_d;

  // RX FIFO
  logic [7:0]    fifo_q [RX_DEPTH];
  logic [7:0]    fifo_d [RX_DEPTH];
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;

  logic          access;
  logic          tx_stall;
  logic          tx_fire;
  logic          fifo_empty;
  logic          fifo_full;
  logic          pop;
  logic          push;
  logic          ovr_set;
  logic          ovr_clr;

  // Inputs that carry no meaning for this register map.
  logic          unused_inputs;
  assign unused_inputs = ^{HSIZE, HPROT, HADDR[31:4], HADDR[1:0], HTRANS[0], HWDATA[31:8]};

  // Bus decode, TX handshake and FIFO bookkeeping
  always_comb begin
    access     = HSEL & HTRANS[1] & HREADY;
    fifo_empty = (count_q == '0);
    fifo_full  = (count_q == FULL_CNT);

    // A TXDATA write may only complete once the core has taken the previous
    // byte: tx_en covers the cycle before the core raises tx_busy.
    tx_stall = wr_act_q & (addr_q == A_TXDATA) & (tx_busy | tx_en_q);
    tx_fire  = wr_act_q & (addr_q == A_TXDATA) & ~(tx_busy | tx_en_q);

    // Reads never stall, so a read data phase completes in its first cycle.
    pop     = rd_act_q & (addr_q == A_RXDATA) & ~fifo_empty;
    push    = rx_valid & (~fifo_full | pop);
    ovr_set = rx_valid & fifo_full & ~pop;
    ovr_clr = rd_act_q & (addr_q == A_STATE);

    rd_act_d = rd_act_q;
    wr_act_d = wr_act_q;
    addr_d   = addr_q;
    if (HREADY) begin
      rd_act_d = access & ~HWRITE;
      wr_act_d = access & HWRITE;
      addr_d   = HADDR[3:2];
    end

    tx_data_d = tx_data_q;
    tx_en_d   = 1'b0;
    if (tx_fire) begin
      tx_data_d = HWDATA[7:0];
      tx_en_d   = 1'b1;
    end

    fifo_d   = fifo_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) begin
      fifo_d[wr_ptr_q] = rx_data;
      wr_ptr_d         = wr_ptr_q + PW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end

    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + (PW+1)'(1);
      2'b01:   count_d = count_q - (PW+1)'(1);
      default: count_d = count_q;
    endcase

    // A new overrun in the same cycle as a STATE read must not be lost.
    overrun_d = overrun_q;
    if (ovr_set) begin
      overrun_d = 1'b1;
    end else if (ovr_clr) begin
      overrun_d = 1'b0;
    end
  end

  // Control and status registers with synchronous reset
  always_ff @(posedge HCLK) begin
    if (!HRESETn) begin
      rd_act_q  <= 1'b0;
      wr_act_q  <= 1'b0;
      addr_q    <= 2'd0;
      tx_data_q <= 8'h00;
      tx_en_q   <= 1'b0;
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
    end else begin
      rd_act_q  <= rd_act_d;
      wr_act_q  <= wr_act_d;
      addr_q    <= addr_d;
      tx_data_q <= tx_data_d;
      tx_en_q   <= tx_en_d;
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
    end
  end

  // FIFO storage; emptied logically by the pointer reset, data left as-is
  always_ff @(posedge HCLK) begin
    fifo_q <= fifo_d;
  end

  // Read data mux from the registered data-phase address
  always_comb begin
    HRDATA = 32'h0;
    if (rd_act_q) begin
      case (addr_q)
        A_RXDATA: HRDATA = fifo_empty ? 32'h0 : {24'h0, fifo_q[rd_ptr_q]};
        A_STATE:  HRDATA = {29'h0, overrun_q, ~fifo_empty, tx_busy | tx_en_q};
        A_TXDATA: HRDATA = {24'h0, tx_data_q};
        default:  HRDATA = 32'h0;
      endcase
    end
  end

  assign HREADYOUT = ~tx_stall;
  assign HRESP     = 1'b0;
  assign tx_data   = tx_data_q;
  assign tx_en     = tx_en_q;
  assign uart_irq  = ~fifo_empty;

endmodule

// File: tb/tb_ahblite_uart.sv
// Scoreboard bench for ahblite_uart: the stimulus process queues expected
// read data, TX bytes and signal probes; one monitor process on the falling
// edge pops and compares them.
module tb_ahblite_uart;

  logic        HCLK = 1'b0;
  logic        HRESETn;
  logic        HSEL;
  logic [31:0] HADDR;
  logic [1:0]  HTRANS;
  logic [2:0]  HSIZE;
  logic [3:0]  HPROT;
  logic        HWRITE;
  logic [31:0] HWDATA;
  logic        HREADY;
  logic        HREADYOUT;
  logic [31:0] HRDATA;
  logic        HRESP;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        tx_busy = 1'b0;
  logic [7:0]  tx_data;
  logic        tx_en;
  logic        uart_irq;

  localparam logic [31:0] A_RX = 32'h4000_0010;
  localparam logic [31:0] A_ST = 32'h4000_0014;
  localparam logic [31:0] A_TX = 32'h4000_0018;
  localparam logic [31:0] A_RS = 32'h4000_001C;

  typedef enum int {P_HREADY, P_TXEN, P_TXDATA, P_IRQ, P_HRDATA, P_TIMEOUT} pkind_t;
  typedef struct {
    pkind_t      kind;
    logic [31:0] exp;
  } probe_t;

  logic [31:0] rd_q[$];
  logic [7:0]  tx_q[$];
  probe_t      pr_q[$];

  int   checks = 0;
  int   errors = 0;
  logic done   = 1'b0;
  logic mon_rd = 1'b0;

  // Single-slave bus: the slave's ready is the bus ready.
  assign HREADY = HREADYOUT;

  ahblite_uart #(.RX_DEPTH(4)) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .HSEL(HSEL), .HADDR(HADDR), .HTRANS(HTRANS),
    .HSIZE(HSIZE), .HPROT(HPROT), .HWRITE(HWRITE), .HWDATA(HWDATA), .HREADY(HREADY),
    .HREADYOUT(HREADYOUT), .HRDATA(HRDATA), .HRESP(HRESP),
    .rx_data(rx_data), .rx_valid(rx_valid), .tx_busy(tx_busy),
    .tx_data(tx_data), .tx_en(tx_en), .uart_irq(uart_irq)
  );

  initial forever #5 HCLK = ~HCLK;

  initial begin
    #200000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

  // TX core model: busy for 10 cycles after each tx_en strobe.
  initial begin
    int cnt;
    cnt = 0;
    forever begin
      @(posedge HCLK); #1;
      if (!HRESETn) begin
        cnt = 0;
        tx_busy = 1'b0;
      end else if (tx_en === 1'b1) begin
        cnt = 10;
        tx_busy = 1'b1;
      end else if (cnt > 0) begin
        cnt = cnt - 1;
        tx_busy = (cnt != 0);
      end
    end
  end

  // Track whether the current cycle is a read data phase.
  always @(posedge HCLK) begin
    if (!HRESETn) mon_rd <= 1'b0;
    else if (HREADY) mon_rd <= HSEL & HTRANS[1] & ~HWRITE;
  end

  // Monitor: compare everything the stimulus queued
  always @(negedge HCLK) begin
    probe_t      pr;
    logic [31:0] act;
    logic [31:0] expv;
    if (mon_rd && HREADYOUT === 1'b1) begin
      checks++;
      if (rd_q.size() == 0) begin
        errors++;
        $display("FAIL rdata unexpected read data phase, got %h", HRDATA);
      end else begin
        expv = rd_q.pop_front();
        if (HRDATA !== expv) begin
          errors++;
          $display("FAIL rdata got %h expected %h at %0t", HRDATA, expv, $time);
        end
      end
    end
    if (tx_en === 1'b1) begin
      checks++;
      if (tx_q.size() == 0) begin
        errors++;
        $display("FAIL tx_byte unexpected tx_en pulse, tx_data %h", tx_data);
      end else begin
        expv = {24'h0, tx_q.pop_front()};
        if ({24'h0, tx_data} !== expv) begin
          errors++;
          $display("FAIL tx_byte got %h expected %h at %0t", tx_data, expv[7:0], $time);
        end
      end
    end
    while (pr_q.size() > 0) begin
      pr = pr_q.pop_front();
      case (pr.kind)
        P_HREADY: act = {31'h0, HREADYOUT};
        P_TXEN:   act = {31'h0, tx_en};
        P_TXDATA: act = {24'h0, tx_data};
        P_IRQ:    act = {31'h0, uart_irq};
        P_HRDATA: act = HRDATA;
        default:  act = 32'h1;
      endcase
      checks++;
      if (act !== pr.exp) begin
        errors++;
        $display("FAIL %s got %h expected %h at %0t", pr.kind.name(), act, pr.exp, $time);
      end
    end
    if (done) begin
      checks++;
      if (rd_q.size() != 0 || tx_q.size() != 0) begin
        errors++;
        $display("FAIL leftovers got rd=%0d tx=%0d expected 0 0", rd_q.size(), tx_q.size());
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
    end
  end

  task automatic probe(input pkind_t k, input logic [31:0] e);
    pr_q.push_back('{k, e});
  endtask

  task automatic bus_idle();
    HSEL = 1'b0; HTRANS = 2'b00; HWRITE = 1'b0;
  endtask

  task automatic addr_phase(input logic wr, input logic [31:0] a);
    HSEL = 1'b1; HTRANS = 2'b10; HWRITE = wr; HADDR = a;
  endtask

  // Advance past the next edge on which the bus is ready.
  task automatic step();
    int n;
    n = 0;
    @(negedge HCLK);
    while (HREADYOUT !== 1'b1 && n < 50) begin
      n++;
      @(negedge HCLK);
    end
    if (n >= 50) probe(P_TIMEOUT, 32'h0);
    @(posedge HCLK); #1;
  endtask

  task automatic idle_step();
    bus_idle();
    step();
  endtask

  task automatic rd(input logic [31:0] a, input logic [31:0] e);
    addr_phase(1'b0, a);
    rd_q.push_back(e);
    step();
  endtask

  task automatic wr(input logic [31:0] a, input logic [31:0] d);
    addr_phase(1'b1, a);
    step();
    HWDATA = d;
  endtask

  task automatic push(input logic [7:0] b);
    rx_data = b; rx_valid = 1'b1;
    @(posedge HCLK); #1;
    rx_valid = 1'b0;
  endtask

  // Stimulus
  initial begin
    HRESETn = 1'b0; HSEL = 1'b0; HADDR = 32'h0; HTRANS = 2'b00; HSIZE = 3'b010;
    HPROT = 4'h0; HWRITE = 1'b0; HWDATA = 32'h0; rx_data = 8'h00; rx_valid = 1'b0;

    // Reset
    repeat (2) begin @(posedge HCLK); #1; end
    probe(P_HREADY, 32'h1); probe(P_TXEN, 32'h0); probe(P_TXDATA, 32'h0);
    probe(P_IRQ, 32'h0); probe(P_HRDATA, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    rd(A_ST, 32'h0);
    idle_step();

    // RX path
    push(8'h41); push(8'h42);
    probe(P_IRQ, 32'h1);
    rd(A_ST, 32'h2);
    rd(A_RX, 32'h41);
    rd(A_RX, 32'h42);
    rd(A_RX, 32'h0);
    idle_step();
    probe(P_IRQ, 32'h0);

    // Overrun
    for (int i = 0; i < 5; i++) push(8'h10 + 8'(i));
    rd(A_ST, 32'h6);
    rd(A_ST, 32'h2);
    for (int i = 0; i < 4; i++) rd(A_RX, 32'h10 + 32'(i));
    idle_step();
    probe(P_IRQ, 32'h0);

    // Full FIFO with simultaneous pop and push
    for (int i = 0; i < 4; i++) push(8'h20 + 8'(i));
    probe(P_IRQ, 32'h1);
    addr_phase(1'b0, A_RX);
    rd_q.push_back(32'h20);
    step();
    rx_data = 8'h55; rx_valid = 1'b1;
    bus_idle();
    step();
    rx_valid = 1'b0;
    rd(A_ST, 32'h2);
    rd(A_RX, 32'h21);
    rd(A_RX, 32'h22);
    rd(A_RX, 32'h23);
    rd(A_RX, 32'h55);
    rd(A_RX, 32'h0);
    idle_step();

    // Ignored writes and reserved offset
    wr(A_RS, 32'hFF);
    wr(A_RX, 32'h99);
    rd(A_RS, 32'h0);
    rd(A_ST, 32'h0);
    idle_step();

    // TX stall: back-to-back TXDATA writes
    addr_phase(1'b1, A_TX);
    step();
    HWDATA = 32'hA5;
    tx_q.push_back(8'hA5);
    probe(P_HREADY, 32'h1);
    addr_phase(1'b1, A_TX);
    step();
    HWDATA = 32'h5A;
    tx_q.push_back(8'h5A);
    probe(P_TXEN, 32'h1);
    probe(P_TXDATA, 32'hA5);
    addr_phase(1'b0, A_ST);
    rd_q.push_back(32'h1);
    for (int i = 0; i < 11; i++) begin
      probe(P_HREADY, (i < 10) ? 32'h0 : 32'h1);
      @(posedge HCLK); #1;
    end
    addr_phase(1'b0, A_TX);
    rd_q.push_back(32'h5A);
    step();
    idle_step();

    // Reset during a stalled TXDATA write
    push(8'h66);
    probe(P_IRQ, 32'h1);
    addr_phase(1'b1, A_TX);
    step();
    HWDATA = 32'h77;
    bus_idle();
    probe(P_HREADY, 32'h0);
    @(posedge HCLK); #1;
    probe(P_HREADY, 32'h0);
    HRESETn = 1'b0;
    @(posedge HCLK); #1;
    probe(P_HREADY, 32'h1); probe(P_TXEN, 32'h0); probe(P_IRQ, 32'h0); probe(P_HRDATA, 32'h0);
    @(posedge HCLK); #1;
    HRESETn = 1'b1;
    rd(A_RX, 32'h0);
    rd(A_ST, 32'h0);
    idle_step();
    idle_step();
    done = 1'b1;
  end

endmodule
